// File: rtl/Purple_Jade_pkg.sv
// Shared front-end/back-end sizing constants.
package Purple_Jade_pkg;

  localparam int unsigned DECODED_INSTRUCTION_WIDTH = 32;
  localparam int unsigned FE_BE_QUEUE_DEPTH         = 8;

endpackage : Purple_Jade_pkg

// File: rtl/fe_be_decode_queue.sv
// Decoupling ring buffer between the front-end decoder and back-end rename.
// Flushed in one cycle on a mispredict so no wrong-path instruction reaches rename.
module fe_be_decode_queue
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned WIDTH_P = DECODED_INSTRUCTION_WIDTH,
  parameter int unsigned DEPTH_P = FE_BE_QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [WIDTH_P-1:0]         fe_decoded_i,
  input  logic                       fe_decoded_v_i,
  output logic                       fe_ready_o,
  output logic [WIDTH_P-1:0]         decoded_o,
  output logic                       decoded_v_o,
  input  logic                       rename_ready_i,
  output logic [$clog2(DEPTH_P):0]   count_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_P);
  localparam int unsigned PTR_W = IDX_W + 1;

  // Reject depths the wrap-bit pointer scheme cannot represent.
  if ((DEPTH_P < 2) || ((DEPTH_P & (DEPTH_P - 1)) != 0)) begin : g_bad_depth
    $error("fe_be_decode_queue: DEPTH_P must be a power of 2 and >= 2");
  end

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               empty, full;
  logic               push_fire, pop_fire;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  // Occupancy and handshake status, all from registered pointers only.
  always_comb begin
    empty       = (rd_ptr_q == wr_ptr_q);
    full        = (rd_idx == wr_idx) && (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
    fe_ready_o  = ~full;
    decoded_v_o = ~empty;
    count_o     = wr_ptr_q - rd_ptr_q;
    decoded_o   = mem_q[rd_idx];
  end

  // Next-pointer logic; a flush discards both sides and snaps rd onto wr.
  always_comb begin
    push_fire = 1'b0;
    pop_fire  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      push_fire = fe_decoded_v_i & ~full;
      pop_fire  = ~empty & rename_ready_i;
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_fire);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_fire);
    end
  end

  // Pointer registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are not reset and only a qualified push writes.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[wr_idx] <= fe_decoded_i;
    end
  end

  // Structural invariants checked in simulation.
  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_decoded_v_i && full) |-> (wr_ptr_d == wr_ptr_q));
  a_count_bound : assert property (@(posedge clk_i) disable iff (reset_i)
    count_o <= PTR_W'(DEPTH_P));
  a_valid_matches_count : assert property (@(posedge clk_i) disable iff (reset_i)
    decoded_v_o == (count_o != '0));

endmodule : fe_be_decode_queue

// File: tb/tb_fe_be_decode_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_fe_be_decode_queue;
  import Purple_Jade_pkg::*;

  localparam int unsigned W = DECODED_INSTRUCTION_WIDTH;
  localparam int unsigned D = FE_BE_QUEUE_DEPTH;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic [W-1:0]  fe_decoded_i;
  logic          fe_decoded_v_i;
  logic          fe_ready_o;
  logic [W-1:0]  decoded_o;
  logic          decoded_v_o;
  logic          rename_ready_i;
  logic [CW-1:0] count_o;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] model_q[$];

  fe_be_decode_queue dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .fe_decoded_i   (fe_decoded_i),
    .fe_decoded_v_i (fe_decoded_v_i),
    .fe_ready_o     (fe_ready_o),
    .decoded_o      (decoded_o),
    .decoded_v_o    (decoded_v_o),
    .rename_ready_i (rename_ready_i),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare visible outputs with the model's current contents.
  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, W'(count_o), W'(model_q.size()));
    chk({tag, ".valid"}, W'(decoded_v_o), W'(model_q.size() != 0));
    chk({tag, ".ready"}, W'(fe_ready_o), W'(model_q.size() < D));
    if (model_q.size() != 0) chk({tag, ".head"}, decoded_o, model_q[0]);
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic v, input logic [W-1:0] data, input logic rr,
                      input logic fl, input string tag);
    bit can_push, can_pop;
    @(negedge clk);
    fe_decoded_v_i = v;
    fe_decoded_i   = data;
    rename_ready_i = rr;
    flush_i        = fl;
    #1;
    check_outputs(tag);
    can_push = v && (model_q.size() < D);
    can_pop  = rr && (model_q.size() != 0);
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (can_pop) void'(model_q.pop_front());
      if (can_push) model_q.push_back(data);
    end
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; fe_decoded_i = '0;
    fe_decoded_v_i = 1'b0; rename_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset_i = 1'b0;

    // Fill to full with rename stalled, then attempt a 9th push.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0, "fill");
    step(1'b1, W'(32'h09), 1'b0, 1'b0, "fill9");
    step(1'b0, '0, 1'b0, 1'b0, "full_hold");
    // Drain in order.
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");

    // Streaming across two pointer wraps.
    for (int i = 0; i < 20; i++) step(1'b1, W'(32'h10 + i), 1'b1, 1'b0, "stream");
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, "stream_end");

    // Full with simultaneous pop: push of 0xAA is blocked for one cycle.
    for (int i = 0; i < 8; i++) step(1'b1, W'(32'hA0 + i), 1'b0, 1'b0, "refill");
    step(1'b1, W'(32'hAA), 1'b1, 1'b0, "full_pop");
    step(1'b1, W'(32'hAA), 1'b1, 1'b0, "full_push");
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0, "drain_aa");

    // Flush with concurrent push and pop.
    for (int i = 0; i < 5; i++) step(1'b1, W'(32'hC0 + i), 1'b0, 1'b0, "pre_flush");
    step(1'b1, W'(32'h55), 1'b1, 1'b1, "flush");
    step(1'b1, W'(32'h66), 1'b0, 1'b0, "post_flush");
    step(1'b0, '0, 1'b1, 1'b0, "after_66");
    // Held flush drops pushes.
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hE0 + i), 1'b1, 1'b1, "flush_hold");
    step(1'b0, '0, 1'b0, 1'b0, "flush_done");

    // Asynchronous reset mid-cycle with contents present.
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hB0 + i), 1'b0, 1'b0, "pre_areset");
    @(negedge clk);
    fe_decoded_v_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    model_q.delete();
    check_outputs("async_reset");
    @(negedge clk);
    reset_i = 1'b0;

    // Reset together with flush while full.
    for (int i = 0; i < 8; i++) step(1'b1, W'(32'hD0 + i), 1'b0, 1'b0, "fill_rst");
    @(negedge clk);
    reset_i = 1'b1; flush_i = 1'b1; fe_decoded_v_i = 1'b1; fe_decoded_i = W'(32'h99);
    #1;
    model_q.delete();
    check_outputs("reset_flush");
    @(posedge clk);
    #1;
    check_outputs("reset_flush_edge");
    @(negedge clk);
    reset_i = 1'b0; flush_i = 1'b0; fe_decoded_v_i = 1'b0;
    step(1'b1, W'(32'h77), 1'b0, 1'b0, "push77");
    step(1'b0, '0, 1'b1, 1'b0, "pop77");
    step(1'b0, '0, 1'b0, 1'b0, "idle77");

    // Random traffic; idle payload driven as X to confirm it never lands.
    for (int i = 0; i < 600; i++) begin
      logic v, rr, fl;
      logic [W-1:0] data;
      v  = ($urandom_range(99) < 70);
      rr = ($urandom_range(99) < 55);
      fl = ($urandom_range(99) < 4);
      data = v ? W'($urandom) : 'x;
      step(v, data, rr, fl, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fe_be_decode_queue

// File: doc/fe_be_decode_queue.md
Name: fe_be_decode_queue

Overview:
- Decoupling ring buffer between the front-end decoder and the back-end rename stage. It absorbs decoder/rename rate mismatch.
- The front end pushes decoded instructions. Rename pops them through a valid/ready handshake.
- The whole queue is flushed when the ROB signals a mispredict, so no wrong-path instruction reaches rename after a redirect.

Parameters:
- WIDTH_P, default DECODED_INSTRUCTION_WIDTH: bits per decoded instruction.
- DEPTH_P, default 8: number of entries. Must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  mispredict flush, driven by the back-end mispredict signal.
- fe_decoded_i  input  WIDTH_P  decoded instruction from the front end.
- fe_decoded_v_i  input  1  front-end push request.
- fe_ready_o  output  1  queue can accept a push this cycle.
- decoded_o  output  WIDTH_P  head entry, feeds the rename decode input.
- decoded_v_o  output  1  head entry is valid.
- rename_ready_i  input  1  rename accepts the head this cycle.
- count_o  output  $clog2(DEPTH_P)+1  current occupancy, 0..DEPTH_P.

Behaviour:
- State:
  - Storage array of DEPTH_P x WIDTH_P.
  - Read and write pointers, each $clog2(DEPTH_P)+1 bits wide; the MSB is the wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and wrap bits differ.
  - count_o = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Reset (asynchronous, takes effect immediately on assertion):
  - rd_ptr = wr_ptr = 0.
  - decoded_v_o = 0, count_o = 0, fe_ready_o = 1.
  - Storage contents are not reset; decoded_o is don't-care while decoded_v_o = 0.
- Push:
  - Push fires when fe_decoded_v_i & fe_ready_o & !flush_i.
  - The entry is written at mem[wr_ptr index] and wr_ptr increments by 1.
- Pop:
  - Pop fires when decoded_v_o & rename_ready_i & !flush_i; rd_ptr increments by 1.
- Handshake outputs:
  - fe_ready_o = !full. It depends only on registered state: no combinational path from rename_ready_i or flush_i.
  - decoded_v_o = !empty, also purely registered.
  - decoded_o = mem[rd_ptr index], a combinational read of the registered array.
- Latency:
  - A push in cycle N is visible at decoded_o/decoded_v_o in cycle N+1. There is no same-cycle bypass.
  - Back-to-back push and pop sustain 1 instruction per cycle.
- Simultaneous push and pop:
  - Both fire and count is unchanged.
  - When full, fe_ready_o = 0, so the push is blocked even if a pop fires that cycle. The slot frees for the next cycle.
  - When empty, only the push can fire.
- Wrap-around: the index rolls DEPTH_P-1 -> 0 and the wrap bit toggles. Ordering is strictly FIFO across the wrap.
- Flush:
  - On the rising edge where flush_i = 1, set rd_ptr <= wr_ptr, which empties the queue.
  - Any push or pop presented in that cycle is discarded. A pop handshake in the flush cycle is not a transfer, and rename ignores it under mispredict.
  - In the cycle after the flush: decoded_v_o = 0, count_o = 0, fe_ready_o = 1.
  - If flush_i is held high for multiple cycles, the queue stays empty and all pushes are dropped.
- Reset mid-operation overrides everything, including a flush in the same cycle. In-flight contents are lost.
- An X on fe_decoded_i while fe_decoded_v_i = 0 must not propagate into any state.
- Assertions (simulation only):
  - A push while full is impossible.
  - count_o <= DEPTH_P.
  - decoded_v_o == (count_o != 0).

Decomposition:
- Purple_Jade_pkg owns DECODED_INSTRUCTION_WIDTH and a new constant FE_BE_QUEUE_DEPTH = 8. The top level passes it as DEPTH_P.
- No typedefs are needed; the payload is opaque.
- No sub-module: pointer logic and storage stay in the one module, about 150 lines.
- Integration: place between the front end and the backend top. decoded_o/decoded_v_o drive the backend decode input. rename_ready_i comes from the rename decode-ready output. flush_i comes from the backend mispredict output.

Test Plan:
- Reset then idle: assert reset_i asynchronously mid-cycle -> decoded_v_o = 0, count_o = 0, fe_ready_o = 1 immediately, with no clock edge needed.
- Fill and drain (DEPTH_P = 8), with rename_ready_i = 0:
  - Push 0x01..0x08 -> count_o reaches 8 and fe_ready_o = 0 in the cycle after the 8th push.
  - A 9th push of 0x09 is not accepted.
  - Raise rename_ready_i -> pops return 0x01..0x08 in order, one per cycle, then decoded_v_o = 0.
- Streaming and wrap: push and pop every cycle for 20 cycles with payloads 0x10..0x23 -> each value appears at decoded_o exactly 1 cycle after its push. count_o stays 1 and order is preserved across two pointer wraps.
- Full with simultaneous pop: queue full (count 8), rename_ready_i = 1, fe_decoded_v_i = 1 with 0xAA -> cycle 1 pop only, count 7. Cycle 2 push accepted, count stays 7. 0xAA emerges after the 7 older entries.
- Flush: 5 entries queued, then flush_i = 1 for one cycle with a concurrent push of 0x55 and rename_ready_i = 1 -> next cycle count_o = 0 and decoded_v_o = 0. 0x55 never appears. A subsequent push of 0x66 appears after 1 cycle.
- Reset during flush and full: assert reset_i and flush_i together with 8 entries queued -> all outputs take reset values. After release, the first push of 0x77 is the first pop.
